// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    // Default scan tick period in clk cycles: 1 ms at 100 MHz.
    localparam int unsigned KEY_SCAN_FREQ = 100000;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Lowest-index active-low row wins when several are low.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-clk scan tick every SCAN_PERIOD cycles.
module scan_tick_gen
    import keypad_scan_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD = KEY_SCAN_FREQ
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with debounce, key handshake and 8-digit key history.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD  = KEY_SCAN_FREQ,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        overrun,
    input  logic        key_clr,
    output logic [31:0] data_out
);

    localparam int unsigned DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT - 1);

    logic          tick;
    logic [3:0]    row_meta, rows_s;
    state_e        state, state_d;
    logic [1:0]    col, col_d;
    logic [3:0]    lat_rows, lat_d;
    logic [DW-1:0] deb_cnt, deb_d, deb_inc;
    logic          accept_c;
    logic [3:0]    new_code_c;
    logic [3:0]    code_d;
    logic          valid_d, ovr_d;
    logic [31:0]   data_d;

    scan_tick_gen #(.SCAN_PERIOD(SCAN_PERIOD)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Rows idle high, so the synchronizer resets to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            rows_s   <= 4'hF;
        end else begin
            row_meta <= row_in;
            rows_s   <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            col       <= 2'd0;
            col_out   <= 4'b1110;
            lat_rows  <= 4'hF;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
            data_out  <= 32'h0;
        end else begin
            state     <= state_d;
            col       <= col_d;
            col_out   <= ~(4'b0001 << col_d);
            lat_rows  <= lat_d;
            deb_cnt   <= deb_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            overrun   <= ovr_d;
            data_out  <= data_d;
        end
    end

    assign deb_inc = deb_cnt + DW'(1);

    // Scan/debounce sequencing plus key handshake and history update.
    always_comb begin
        state_d  = state;
        col_d    = col;
        lat_d    = lat_rows;
        deb_d    = deb_cnt;
        accept_c = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (rows_s != 4'hF) begin
                        lat_d   = rows_s;
                        deb_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s == lat_rows) begin
                        if (deb_inc >= DEB_LAST) begin
                            accept_c = 1'b1;
                            state_d  = ST_HELD;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (rows_s == 4'hF) begin
                        deb_d   = '0;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (rows_s == 4'hF) begin
                        if (deb_inc >= DEB_LAST) state_d = ST_SCAN;
                        else                     deb_d   = deb_inc;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        new_code_c = KEY_MAP[{low_row(lat_rows), col}];
        code_d     = key_code;
        valid_d    = key_valid;
        ovr_d      = overrun;
        data_d     = data_out;
        if (key_valid && key_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (key_clr) data_d = 32'h0;
        if (accept_c) begin
            code_d  = new_code_c;
            valid_d = 1'b1;
            if (key_valid && !key_ack) ovr_d = 1'b1;
            data_d  = {data_d[27:0], new_code_c};
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan with a keypad model and key scoreboard.
module tb_keypad_scan;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        overrun;
    logic        key_clr;
    logic [31:0] data_out;

    logic [15:0] pressed;
    logic [3:0]  row_force;
    logic        mon_en;
    int          checks;
    int          errors;
    exp_t        sb_q[$];
    logic [3:0]  keymap_ref [4][4];

    keypad_scan #(.SCAN_PERIOD(4), .DEBOUNCE_CNT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .overrun  (overrun),
        .key_clr  (key_clr),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is driven low.
    assign row_in[0] = ~(|(pressed[3:0]   & ~col_out)) & ~row_force[0];
    assign row_in[1] = ~(|(pressed[7:4]   & ~col_out)) & ~row_force[1];
    assign row_in[2] = ~(|(pressed[11:8]  & ~col_out)) & ~row_force[2];
    assign row_in[3] = ~(|(pressed[15:12] & ~col_out)) & ~row_force[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!key_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!key_valid) timeout(name);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col_out == target && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (col_out != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (col_out != target) timeout("wait_col");
    endtask

    task automatic press_key(input int r, input int c);
        pressed = pressed | (16'h1 << (4 * r + c));
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    // Monitor: every fresh key_valid must match the oldest expected key.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && key_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got %h expected none", key_code);
                end else begin
                    e = sb_q.pop_front();
                    check("mon_code", 32'(key_code), 32'(e.code));
                    check("mon_data", data_out, e.data);
                    check("mon_overrun", 32'(overrun), 32'h0);
                end
            end
            prev_valid = key_valid;
        end
    end

    initial begin
        int          n;
        int          last_chg;
        int          r1, r2, c, hold;
        logic [3:0]  prev;
        logic [3:0]  code;
        logic [31:0] data_model;
        exp_t        e;

        keymap_ref = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                       '{4'h4, 4'h5, 4'h6, 4'hB},
                       '{4'h7, 4'h8, 4'h9, 4'hC},
                       '{4'hE, 4'h0, 4'hF, 4'hD}};
        checks = 0; errors = 0; mon_en = 1'b0;
        pressed = 16'h0; row_force = 4'h0;
        key_ack = 1'b0; key_clr = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_out), 32'hE);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_data", data_out, 32'h0);
        rst_n = 1'b1;

        // Idle scan: columns rotate one position every 4 clocks.
        prev = col_out; last_chg = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_out != prev) begin
                check("scan_order", 32'(col_out), 32'({prev[2:0], prev[3]}));
                if (last_chg >= 0) check("scan_period", 32'(i - last_chg), 32'd4);
                last_chg = i;
                prev = col_out;
            end
        end
        if (last_chg < 0) timeout("scan_idle");
        check("idle_valid", 32'(key_valid), 32'h0);
        check("idle_data", data_out, 32'h0);

        // Key 6 (row 1, column 2), then acknowledge.
        press_key(1, 2);
        wait_valid("key6");
        check("key6_code", 32'(key_code), 32'h6);
        check("key6_data", data_out, 32'h6);
        pulse_ack();
        check("key6_ack", 32'(key_valid), 32'h0);
        pressed = 16'h0;
        repeat (40) @(negedge clk);

        // Bounce: row 0 low for one tick only; column dwell stretches, no key.
        wait_col(4'b1110);
        row_force = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 4) row_force = 4'h0;
        end while (col_out == 4'b1110 && n < 40);
        check("bounce_dwell", 32'(n), 32'd12);
        check("bounce_next_col", 32'(col_out), 32'hD);
        repeat (30) @(negedge clk);
        check("bounce_valid", 32'(key_valid), 32'h0);
        check("bounce_data", data_out, 32'h6);

        // key_clr alone empties the history.
        key_clr = 1'b1;
        @(negedge clk);
        key_clr = 1'b0;
        check("clr_data", data_out, 32'h0);
        check("clr_valid", 32'(key_valid), 32'h0);

        // Overrun: 5 then 9 without acknowledge.
        press_key(1, 1);
        wait_valid("key5");
        check("key5_code", 32'(key_code), 32'h5);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        press_key(2, 2);
        n = 0;
        while (data_out[3:0] != 4'h9 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ovr_code", 32'(key_code), 32'h9);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_valid", 32'(key_valid), 32'h1);
        check("ovr_data", data_out, 32'h59);
        pulse_ack();
        check("ovr_ack_flag", 32'(overrun), 32'h0);
        check("ovr_ack_valid", 32'(key_valid), 32'h0);
        pressed = 16'h0;
        repeat (40) @(negedge clk);

        // Ack and clear in the same cycle as the accept of A.
        press_key(0, 0);
        wait_valid("key1");
        check("key1_code", 32'(key_code), 32'h1);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        wait_col(4'b0111);
        press_key(0, 3);
        repeat (11) @(negedge clk);
        key_ack = 1'b1; key_clr = 1'b1;
        @(negedge clk);
        key_ack = 1'b0; key_clr = 1'b0;
        check("same_valid", 32'(key_valid), 32'h1);
        check("same_code", 32'(key_code), 32'hA);
        check("same_overrun", 32'(overrun), 32'h0);
        check("same_data", data_out, 32'hA);
        @(negedge clk);
        check("same_valid_hold", 32'(key_valid), 32'h1);
        pulse_ack();
        pressed = 16'h0;
        repeat (40) @(negedge clk);

        // Reset during debounce of key 8 discards it.
        wait_col(4'b1101);
        press_key(2, 1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", 32'(col_out), 32'hE);
        check("mid_rst_valid", 32'(key_valid), 32'h0);
        check("mid_rst_code", 32'(key_code), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_data", data_out, 32'h0);
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_valid", 32'(key_valid), 32'h0);
        check("post_rst_data", data_out, 32'h0);

        // Random presses (some two-row same-column) and sub-debounce bounces.
        mon_en = 1'b1;
        data_model = 32'h0;
        for (int k = 0; k < 24; k++) begin
            c = int'($urandom_range(0, 3));
            r1 = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                press_key(r1, c);
                hold = int'($urandom_range(1, 5));
                repeat (hold) @(negedge clk);
                pressed = 16'h0;
                repeat (30) @(negedge clk);
            end else begin
                r2 = r1;
                if ($urandom_range(0, 3) == 0) r2 = int'($urandom_range(0, 3));
                code = keymap_ref[(r1 < r2) ? r1 : r2][c];
                data_model = {data_model[27:0], code};
                e.code = code;
                e.data = data_model;
                sb_q.push_back(e);
                press_key(r1, c);
                press_key(r2, c);
                repeat (60) @(negedge clk);
                pulse_ack();
                pressed = 16'h0;
                repeat (40) @(negedge clk);
            end
        end
        repeat (20) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
